// File: rtl/uart_boot_loader.sv
// UART boot loader: receives an image frame (MAGIC, len lo, len hi, len*4 bytes)
// over 8N1 UART, writes it word-by-word into instruction memory and holds the core
// in reset until the load completes.
// Optional macro BOOT_CHECKSUM_EN adds a trailing XOR checksum byte to the frame.
module uart_boot_loader #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned ADDR_W   = 10,
  parameter logic [7:0]  MAGIC    = 8'hA5
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              frame_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CntHalf = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]      MaxLen  = 32'd1 << ADDR_W;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {
    LdWaitMagic, LdLenLo, LdLenHi, LdPayload, LdCheck, LdDone
  } ld_state_e;
  localparam ld_state_e LdAfterBody = LdCheck;
`else
  typedef enum logic [2:0] {
    LdWaitMagic, LdLenLo, LdLenHi, LdPayload, LdDone
  } ld_state_e;
  localparam ld_state_e LdAfterBody = LdDone;
`endif

  logic r_rx_meta, r_rx_sync;

  rx_state_e        r_rx_state, w_rx_state_nxt;
  logic [CNT_W-1:0] r_baud_cnt, w_baud_cnt_nxt;
  logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             w_byte_valid, w_rx_abort;

  ld_state_e        r_ld_state, w_ld_state_nxt;
  logic [15:0]      r_len, w_len_nxt, w_len_full;
  logic [ADDR_W-1:0] r_word_idx, w_word_idx_nxt;
  logic [1:0]       r_lane, w_lane_nxt;
  logic [31:0]      r_wbuf, w_wbuf_nxt;
  logic             r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [31:0]      r_wdata, w_wdata_nxt;
  logic             r_frame_err, w_err_set;
  logic             r_load_done;
  logic             w_last_word;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]       r_csum, w_csum_nxt;
`endif

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // RX state and datapath registers.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_rx_state <= RxIdle;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
    end
  end

  // RX next state: mid-bit sampling; byte_valid/rx_abort are single-cycle strobes in STOP.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_baud_cnt_nxt = r_baud_cnt + 1'b1;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_byte_valid   = 1'b0;
    w_rx_abort     = 1'b0;
    case (r_rx_state)
      RxIdle: begin
        w_baud_cnt_nxt = '0;
        if (!r_rx_sync) w_rx_state_nxt = RxStart;
      end
      RxStart: begin
        if (r_baud_cnt == CntHalf) begin
          w_baud_cnt_nxt = '0;
          w_bit_cnt_nxt  = '0;
          w_rx_state_nxt = r_rx_sync ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (r_baud_cnt == CntFull) begin
          w_baud_cnt_nxt = '0;
          w_shift_nxt    = {r_rx_sync, r_shift[7:1]};
          w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_rx_state_nxt = RxStop;
        end
      end
      RxStop: begin
        if (r_baud_cnt == CntFull) begin
          w_baud_cnt_nxt = '0;
          w_rx_state_nxt = RxIdle;
          if (r_rx_sync) w_byte_valid = 1'b1;
          else           w_rx_abort   = 1'b1;
        end
      end
      default: w_rx_state_nxt = RxIdle;
    endcase
  end

  // Loader state, write port and status registers.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_ld_state  <= LdWaitMagic;
      r_len       <= '0;
      r_word_idx  <= '0;
      r_lane      <= '0;
      r_wbuf      <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_frame_err <= 1'b0;
      r_load_done <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      r_ld_state  <= w_ld_state_nxt;
      r_len       <= w_len_nxt;
      r_word_idx  <= w_word_idx_nxt;
      r_lane      <= w_lane_nxt;
      r_wbuf      <= w_wbuf_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_frame_err <= r_frame_err | w_err_set;
      // One cycle behind DONE so the release lands the cycle after the final strobe.
      r_load_done <= (r_ld_state == LdDone);
`ifdef BOOT_CHECKSUM_EN
      r_csum      <= w_csum_nxt;
`endif
    end
  end

  assign w_len_full  = {r_shift, r_len[7:0]};
  assign w_last_word = ({{(32 - ADDR_W){1'b0}}, r_word_idx} == ({16'b0, r_len} - 32'd1));

  // Loader next state: frame parsing, word assembly and write strobe generation.
  always_comb begin
    w_ld_state_nxt = r_ld_state;
    w_len_nxt      = r_len;
    w_word_idx_nxt = r_word_idx;
    w_lane_nxt     = r_lane;
    w_wbuf_nxt     = r_wbuf;
    w_we_nxt       = 1'b0;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_err_set      = w_rx_abort;
`ifdef BOOT_CHECKSUM_EN
    w_csum_nxt     = r_csum;
`endif
    case (r_ld_state)
      LdWaitMagic: begin
        if (w_byte_valid && (r_shift == MAGIC)) w_ld_state_nxt = LdLenLo;
      end
      LdLenLo: begin
        if (w_rx_abort) begin
          w_ld_state_nxt = LdWaitMagic;
        end else if (w_byte_valid) begin
          w_len_nxt[7:0] = r_shift;
          w_ld_state_nxt = LdLenHi;
        end
      end
      LdLenHi: begin
        if (w_rx_abort) begin
          w_ld_state_nxt = LdWaitMagic;
        end else if (w_byte_valid) begin
          w_len_nxt      = w_len_full;
          w_word_idx_nxt = '0;
          w_lane_nxt     = '0;
`ifdef BOOT_CHECKSUM_EN
          w_csum_nxt     = '0;
`endif
          if (w_len_full == 16'd0) begin
            w_ld_state_nxt = LdAfterBody;
          end else if ({16'b0, w_len_full} > MaxLen) begin
            w_err_set      = 1'b1;
            w_ld_state_nxt = LdWaitMagic;
          end else begin
            w_ld_state_nxt = LdPayload;
          end
        end
      end
      LdPayload: begin
        if (w_rx_abort) begin
          w_ld_state_nxt = LdWaitMagic;
        end else if (w_byte_valid) begin
          w_wbuf_nxt[{r_lane, 3'b000} +: 8] = r_shift;
          w_lane_nxt = r_lane + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          w_csum_nxt = r_csum ^ r_shift;
`endif
          if (r_lane == 2'd3) begin
            w_we_nxt       = 1'b1;
            w_addr_nxt     = r_word_idx;
            w_wdata_nxt    = {r_shift, r_wbuf[23:0]};
            w_word_idx_nxt = r_word_idx + 1'b1;
            if (w_last_word) w_ld_state_nxt = LdAfterBody;
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      LdCheck: begin
        if (w_rx_abort) begin
          w_ld_state_nxt = LdWaitMagic;
        end else if (w_byte_valid) begin
          if (r_shift == r_csum) begin
            w_ld_state_nxt = LdDone;
          end else begin
            w_err_set      = 1'b1;
            w_ld_state_nxt = LdWaitMagic;
          end
        end
      end
`endif
      LdDone: ;
      default: w_ld_state_nxt = LdWaitMagic;
    endcase
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign load_done  = r_load_done;
  assign cpu_hold   = ~r_load_done;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: directed frames plus randomized byte
// streams checked against a frame-level reference parser.
`timescale 1ns/1ps
module tb_uart_boot_loader;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;
  localparam logic [7:0]  MAGIC    = 8'hA5;

  logic              sys_clk = 1'b0;
  logic              rst     = 1'b0;
  logic              uart_rx = 1'b1;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              frame_err;

  uart_boot_loader #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .ADDR_W  (ADDR_W),
    .MAGIC   (MAGIC)
  ) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .frame_err (frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write-port and release monitor, sampled on the falling edge.
  int                 cyc = 0;
  logic [ADDR_W+31:0] got_q[$];
  int                 last_we_cyc = 0;
  int                 done_cyc = 0;
  bit                 done_seen = 0;

  always @(posedge sys_clk) cyc++;

  always @(negedge sys_clk) begin
    if (rst) begin
      if (imem_we) begin
        got_q.push_back({imem_addr, imem_wdata});
        last_we_cyc = cyc;
      end
      if (load_done && !done_seen) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
    end
  end

  // Byte stream to send; s_bad marks bytes sent with a 0 stop bit.
  logic [7:0]  s_byte[$];
  bit          s_bad[$];
  logic [31:0] f_words[$];

  task automatic push(input logic [7:0] b, input bit bad);
    s_byte.push_back(b);
    s_bad.push_back(bad);
  endtask

  task automatic push_frame(input logic [7:0] csum_flip);
    logic [7:0]  x;
    logic [15:0] len;
    x   = 8'h00;
    len = 16'(f_words.size());
    push(MAGIC, 0);
    push(len[7:0], 0);
    push(len[15:8], 0);
    foreach (f_words[w]) begin
      for (int k = 0; k < 4; k++) begin
        push(f_words[w][8*k +: 8], 0);
        x ^= f_words[w][8*k +: 8];
      end
    end
`ifdef BOOT_CHECKSUM_EN
    push(x ^ csum_flip, 0);
`endif
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    drive_bit(1'b0);
    for (int k = 0; k < 8; k++) drive_bit(b[k]);
    drive_bit(!bad);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(posedge sys_clk);
    #1;
  endtask

  task automatic run_stream();
    foreach (s_byte[i]) send_byte(s_byte[i], s_bad[i]);
    repeat (40) @(posedge sys_clk);
    #1;
  endtask

  // Reference parser: walks the byte stream frame by frame.
  logic [ADDR_W+31:0] exp_wr[$];
  bit                 exp_done;
  bit                 exp_err;
  int                 mi;

  task automatic take(output logic [7:0] b, output bit ok);
    ok = 0;
    b  = 8'h00;
    if (mi < s_byte.size()) begin
      b = s_byte[mi];
      mi++;
      if (s_bad[mi-1]) exp_err = 1;
      else             ok = 1;
    end
  endtask

  task automatic run_model();
    logic [7:0]  b, lo, hi, x;
    logic [31:0] word;
    bit          ok, good;
    int          len;
    exp_wr.delete();
    exp_done = 0;
    exp_err  = 0;
    mi       = 0;
    word     = 0;
    while (mi < s_byte.size() && !exp_done) begin
      take(b, ok);
      if (!ok || b != MAGIC) continue;
      take(lo, ok);
      if (!ok) continue;
      take(hi, ok);
      if (!ok) continue;
      len = int'({hi, lo});
      if (len > (1 << ADDR_W)) begin
        exp_err = 1;
        continue;
      end
      x    = 8'h00;
      good = 1;
      for (int w = 0; w < len && good; w++) begin
        for (int k = 0; k < 4 && good; k++) begin
          take(b, ok);
          if (!ok) good = 0;
          else begin
            word[8*k +: 8] = b;
            x ^= b;
          end
        end
        if (good) exp_wr.push_back({ADDR_W'(w), word});
      end
      if (!good) continue;
`ifdef BOOT_CHECKSUM_EN
      take(b, ok);
      if (!ok) continue;
      if (b != x) begin
        exp_err = 1;
        continue;
      end
`endif
      exp_done = 1;
    end
  endtask

  task automatic compare(input string tag);
    run_model();
    check({tag, ".n_wr"}, 64'(got_q.size()), 64'(exp_wr.size()));
    for (int i = 0; i < got_q.size() && i < exp_wr.size(); i++)
      check($sformatf("%s.wr%0d", tag, i), 64'(got_q[i]), 64'(exp_wr[i]));
    check({tag, ".load_done"}, 64'(load_done), 64'(exp_done));
    check({tag, ".cpu_hold"},  64'(cpu_hold),  64'(!exp_done));
    check({tag, ".frame_err"}, 64'(frame_err), 64'(exp_err));
    if (exp_wr.size() > 0)
      check({tag, ".hold_last"}, 64'({imem_addr, imem_wdata}), 64'(exp_wr[exp_wr.size()-1]));
    if (exp_done && exp_wr.size() > 0 && done_seen)
      check({tag, ".release_lat"}, 64'(done_cyc - last_we_cyc), 64'd1);
  endtask

  // Asserts reset between clock edges so the asynchronous clear is observed directly.
  task automatic async_reset(input string tag);
    @(negedge sys_clk);
    rst = 1'b0;
    #1;
    check({tag, ".rst_we"},    64'(imem_we),    64'd0);
    check({tag, ".rst_addr"},  64'(imem_addr),  64'd0);
    check({tag, ".rst_wdata"}, 64'(imem_wdata), 64'd0);
    check({tag, ".rst_hold"},  64'(cpu_hold),   64'd1);
    check({tag, ".rst_done"},  64'(load_done),  64'd0);
    check({tag, ".rst_err"},   64'(frame_err),  64'd0);
    got_q.delete();
    done_seen = 0;
    s_byte.delete();
    s_bad.delete();
    f_words.delete();
    repeat (2) @(posedge sys_clk);
    #1;
    rst = 1'b1;
    @(posedge sys_clk);
    #1;
  endtask

  logic [7:0] jb;

  initial begin
    repeat (3) @(posedge sys_clk);
    #1;
    check("por.hold", 64'(cpu_hold), 64'd1);
    check("por.done", 64'(load_done), 64'd0);
    check("por.we",   64'(imem_we), 64'd0);
    rst = 1'b1;
    repeat (60) @(posedge sys_clk);
    #1;
    check("idle.n_wr", 64'(got_q.size()), 64'd0);
    check("idle.hold", 64'(cpu_hold), 64'd1);
    check("idle.done", 64'(load_done), 64'd0);
    check("idle.err",  64'(frame_err), 64'd0);

    // Two-word image.
    f_words.push_back(32'h12345678);
    f_words.push_back(32'hDEADBEEF);
    push_frame(8'h00);
    run_stream();
    compare("two_words");
    async_reset("two_words");

    // Leading garbage before the magic byte.
    push(8'h00, 0);
    push(8'hFF, 0);
    f_words.push_back(32'h04030201);
    push_frame(8'h00);
    run_stream();
    compare("lead_junk");
    async_reset("lead_junk");

    // Partial frame killed by a framing error, then a clean frame.
    push(MAGIC, 0); push(8'h01, 0); push(8'h00, 0); push(8'h11, 0); push(8'h22, 0);
    push(8'h33, 1);
    f_words.push_back(32'hDDCCBBAA);
    push_frame(8'h00);
    run_stream();
    compare("stop_err");
    async_reset("stop_err");

    // Reset mid-frame, then a full frame.
    push(MAGIC, 0); push(8'h01, 0); push(8'h00, 0); push(8'h01, 0); push(8'h02, 0);
    run_stream();
    async_reset("mid_rst");
    f_words.push_back(32'h04030201);
    push_frame(8'h00);
    run_stream();
    compare("after_rst");
    async_reset("after_rst");

    // Oversize length is rejected; zero length releases the core immediately.
    push(MAGIC, 0); push(8'h01, 0); push(8'h04, 0);
    push_frame(8'h00);
    run_stream();
    compare("len_bounds");
    async_reset("len_bounds");

`ifdef BOOT_CHECKSUM_EN
    f_words.push_back(32'h04030201);
    push_frame(8'h01);
    run_stream();
    compare("csum_bad");
    async_reset("csum_bad");
`endif

    for (int t = 0; t < 10; t++) begin
      repeat ($urandom_range(0, 2)) begin
        jb = 8'($urandom);
        if (jb == MAGIC) jb = 8'h00;
        push(jb, $urandom_range(0, 3) == 0);
      end
      case ($urandom_range(0, 3))
        1: begin
          push(MAGIC, 0); push(8'h01, 0); push(8'h00, 0);
          repeat ($urandom_range(0, 3)) push(8'($urandom), 0);
          push(8'($urandom), 1);
        end
        2: begin
          push(MAGIC, 0); push(8'h01, 0); push(8'h04, 0);
        end
        default: ;
      endcase
      repeat ($urandom_range(0, 4)) f_words.push_back($urandom);
      push_frame(($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      repeat ($urandom_range(0, 2)) push(8'($urandom), 0);
      run_stream();
      compare($sformatf("rand%0d", t));
      async_reset($sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
